alu_seq_exec: RTL and testbench
===============================

# alu_seq_exec

Parametrised successor of the combinational ALU-control decoder: accepts an ALUop/funct pair plus two WIDTH-bit operands over a valid/ready handshake, decodes the operation, executes it, and returns a registered result with zero/overflow flags. Single-cycle ops complete in one cycle. Shifts run on an iterative one-bit shifter; the optional multiply runs on an iterative shift-add unit. Sits in the EX stage of the multi-cycle datapath, between the main control unit and the register-file write-back mux.

## Interface

Parameters:
- WIDTH, 32, operand/result width; must be a power of two, ≥ 8
- SHW, $clog2(WIDTH), shift-amount width (derived, do not override)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-low reset
- in_valid  in  1  request present
- in_ready  out  1  block can accept; high only in IDLE and only while rst is high
- in_alu_op  in  2  00 load/store (add), 01 branch (sub), 10 R-type (decode funct), 11 reserved (add)
- in_funct  in  6  R-type funct field
- in_a  in  WIDTH  operand A (rs)
- in_b  in  WIDTH  operand B (rt/imm); for shifts, in_b[SHW-1:0] is the shift amount k
- out_valid  out  1  result valid, held until consumed
- out_ready  in  1  consumer accepts result
- out_result  out  WIDTH  result
- out_zero  out  1  out_result == 0
- out_ovf  out  1  signed overflow (add/sub only, else 0)

## Operation

- Transfer in: in_valid && in_ready at a rising edge (E0). Operands, decoded op and k are captured at E0; inputs are ignored afterwards.
- R-type decode (alu_op=10):
  - 100000 add
  - 100010 sub
  - 100100 and
  - 100101 or
  - 100110 xor
  - 100111 nor
  - 101010 slt (signed, result 1/0)
  - 101011 sltu
  - 000000 sll
  - 000010 srl
  - 000011 sra
  - 011001 multu (only with the macro below)
  - any other funct: add
- Arithmetic: add/sub are modulo 2^WIDTH. out_ovf = (sign a == sign b' ) && (sign result != sign a), where b' = b for add and ~b for sub.
- FSM states: IDLE, SHIFT, MULT, DONE.
  - IDLE, transfer of a single-cycle op → result registered → DONE.
  - IDLE, transfer of a shift with k=0 → DONE, result = a.
  - IDLE, transfer of a shift with k>0 → load a, count=k → SHIFT.
  - SHIFT: each edge shifts 1 bit (sra replicates the MSB) and decrements count. count reaching 0 → DONE.
  - MULT: WIDTH iterations of shift-add. Result is the low WIDTH bits of the unsigned product. Then → DONE.
  - DONE: out_valid=1. out_valid && out_ready → IDLE.
- out_zero and out_ovf are registered together with out_result and are stable throughout DONE.
- Outputs are held unchanged while out_valid && !out_ready.

## Timing

- Reset (rst=0 at an edge), from any state including mid-SHIFT/MULT:
  - state → IDLE; in-flight op discarded
  - out_valid=0, out_result=0, out_zero=0, out_ovf=0, count=0
  - in_ready=0 while rst=0, 1 on the first cycle after rst returns high
- Latency, from E0 to the first cycle with out_valid=1:
  - single-cycle ops: 1 cycle
  - shift by k: k+1 cycles
  - multu: WIDTH+1 cycles
- Throughput: one op in flight. in_ready=0 in SHIFT, MULT and DONE.
- Minimum op-to-op spacing is 2 cycles: DONE→IDLE on consume, accept on the next edge.
- in_valid asserted while in_ready=0 is neither captured nor lost. The requester must hold it.
- out_ready while out_valid=0 has no effect.

## Configuration

- ALU_SEQ_MULT_EN defined: MULT state and shift-add datapath compiled in; funct 011001 executes multu.
- ALU_SEQ_MULT_EN undefined: no MULT state or multiplier logic; funct 011001 decodes as add, latency 1.

## Test plan

- Reset, then alu_op=00, a=5, b=7 → out_valid exactly 1 cycle after E0, result=12, zero=0, ovf=0. Hold out_ready=0 for 3 cycles → outputs stable and in_ready=0.
- alu_op=10, funct=100010, a=0x80000000, b=1 → result=0x7FFFFFFF, ovf=1. Then funct=101010, a=0xFFFFFFFF, b=0 → result=1. Then funct=101011 with the same operands → result=0.
- funct=000011, a=0x80000000, b=4 → out_valid after 5 cycles, result=0xF8000000. Then funct=000000, b=0 → latency 1, result=a.
- alu_op=01, a=b=0x1234 → result=0, zero=1. Then alu_op=11 and funct=111111 (with alu_op=10), a=3, b=4 → result=7 in both cases.
- Start sll with k=20, drop rst low at the 6th cycle → next cycle out_valid=0, result=0. After rst returns high, in_ready=1 and a new add completes correctly.
- With ALU_SEQ_MULT_EN: funct=011001, a=0x10001, b=0x10001 → out_valid after 33 cycles, result=0x00020001. Without the macro, the same stimulus → result=0x00020002 after 1 cycle.

Source files
------------

// File: rtl/alu_seq_exec.sv
// EX-stage sequential ALU: decodes ALUop/funct, executes over a valid/ready handshake.
// Optional iterative multu enabled with `define ALU_SEQ_MULT_EN.
module alu_seq_exec #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_alu_op,
  input  logic [5:0]       in_funct,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_ovf
);

`ifdef ALU_SEQ_MULT_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1, S_MULT = 2'd2, S_DONE = 2'd3} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1, S_DONE = 2'd3} state_t;
`endif

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLT, OP_SLTU,
    OP_SLL, OP_SRL, OP_SRA, OP_MULTU
  } op_t;

  state_t           r_state;
  state_t           w_nextState;
  op_t              r_op;
  op_t              w_op;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_ovf;
  logic [WIDTH-1:0] r_acc;
  logic [SHW-1:0]   r_count;
  logic [WIDTH-1:0] w_bEff;
  logic [WIDTH-1:0] w_sum;
  logic             w_isSub;
  logic             w_addOvf;
  logic [WIDTH-1:0] w_aluRes;
  logic             w_aluOvf;
  logic [WIDTH-1:0] w_shiftNext;
  logic [SHW-1:0]   w_k;
  logic             w_isShift;
  logic             w_accept;
`ifdef ALU_SEQ_MULT_EN
  logic [WIDTH-1:0] r_mplr;
  logic [WIDTH-1:0] r_prod;
  logic [WIDTH-1:0] w_prodNext;
  logic             w_isMult;
`endif

  assign in_ready   = rst && (r_state == S_IDLE);
  assign w_accept   = in_valid && in_ready;
  assign out_valid  = (r_state == S_DONE);
  assign out_result = r_result;
  assign out_zero   = r_zero;
  assign out_ovf    = r_ovf;
  assign w_k        = in_b[SHW-1:0];
  assign w_isShift  = (w_op == OP_SLL) || (w_op == OP_SRL) || (w_op == OP_SRA);
`ifdef ALU_SEQ_MULT_EN
  assign w_isMult   = (w_op == OP_MULTU);
  assign w_prodNext = r_mplr[0] ? (r_prod + r_acc) : r_prod;
`endif

  // Unknown functs and the reserved ALUop fall back to add.
  always_comb begin
    w_op = OP_ADD;
    case (in_alu_op)
      2'b01: w_op = OP_SUB;
      2'b10: begin
        case (in_funct)
          6'b100000: w_op = OP_ADD;
          6'b100010: w_op = OP_SUB;
          6'b100100: w_op = OP_AND;
          6'b100101: w_op = OP_OR;
          6'b100110: w_op = OP_XOR;
          6'b100111: w_op = OP_NOR;
          6'b101010: w_op = OP_SLT;
          6'b101011: w_op = OP_SLTU;
          6'b000000: w_op = OP_SLL;
          6'b000010: w_op = OP_SRL;
          6'b000011: w_op = OP_SRA;
`ifdef ALU_SEQ_MULT_EN
          6'b011001: w_op = OP_MULTU;
`endif
          default:   w_op = OP_ADD;
        endcase
      end
      default: w_op = OP_ADD;
    endcase
  end

  always_comb begin
    w_isSub  = (w_op == OP_SUB);
    w_bEff   = w_isSub ? ~in_b : in_b;
    w_sum    = in_a + w_bEff + {{(WIDTH-1){1'b0}}, w_isSub};
    w_addOvf = (in_a[WIDTH-1] == w_bEff[WIDTH-1]) && (w_sum[WIDTH-1] != in_a[WIDTH-1]);
    w_aluRes = w_sum;
    w_aluOvf = 1'b0;
    case (w_op)
      OP_ADD, OP_SUB: w_aluOvf = w_addOvf;
      OP_AND:  w_aluRes = in_a & in_b;
      OP_OR:   w_aluRes = in_a | in_b;
      OP_XOR:  w_aluRes = in_a ^ in_b;
      OP_NOR:  w_aluRes = ~(in_a | in_b);
      OP_SLT:  w_aluRes = {{(WIDTH-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
      OP_SLTU: w_aluRes = {{(WIDTH-1){1'b0}}, (in_a < in_b)};
      default: w_aluRes = w_sum;
    endcase
  end

  always_comb begin
    case (r_op)
      OP_SLL:  w_shiftNext = {r_acc[WIDTH-2:0], 1'b0};
      OP_SRL:  w_shiftNext = {1'b0, r_acc[WIDTH-1:1]};
      default: w_shiftNext = {r_acc[WIDTH-1], r_acc[WIDTH-1:1]};
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_isShift && (w_k != '0)) w_nextState = S_SHIFT;
`ifdef ALU_SEQ_MULT_EN
          else if (w_isMult)            w_nextState = S_MULT;
`endif
          else                          w_nextState = S_DONE;
        end
      end
      S_SHIFT: if (r_count == SHW'(1)) w_nextState = S_DONE;
`ifdef ALU_SEQ_MULT_EN
      S_MULT:  if (r_count == '0) w_nextState = S_DONE;
`endif
      S_DONE:  if (out_ready) w_nextState = S_IDLE;
      default: w_nextState = S_IDLE;
    endcase
  end

  // Multiply reuses r_acc as the left-shifting multiplicand and r_count as the iteration counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_result <= '0;
      r_zero   <= 1'b0;
      r_ovf    <= 1'b0;
      r_acc    <= '0;
      r_count  <= '0;
      r_op     <= OP_ADD;
`ifdef ALU_SEQ_MULT_EN
      r_mplr   <= '0;
      r_prod   <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op <= w_op;
            if (w_isShift && (w_k == '0)) begin
              r_result <= in_a;
              r_zero   <= (in_a == '0);
              r_ovf    <= 1'b0;
            end else if (w_isShift) begin
              r_acc   <= in_a;
              r_count <= w_k;
            end
`ifdef ALU_SEQ_MULT_EN
            else if (w_isMult) begin
              r_acc   <= in_a;
              r_mplr  <= in_b;
              r_prod  <= '0;
              r_count <= '1;
            end
`endif
            else begin
              r_result <= w_aluRes;
              r_zero   <= (w_aluRes == '0);
              r_ovf    <= w_aluOvf;
            end
          end
        end
        S_SHIFT: begin
          r_acc   <= w_shiftNext;
          r_count <= r_count - 1'b1;
          if (r_count == SHW'(1)) begin
            r_result <= w_shiftNext;
            r_zero   <= (w_shiftNext == '0);
            r_ovf    <= 1'b0;
          end
        end
`ifdef ALU_SEQ_MULT_EN
        S_MULT: begin
          r_acc  <= {r_acc[WIDTH-2:0], 1'b0};
          r_mplr <= {1'b0, r_mplr[WIDTH-1:1]};
          r_prod <= w_prodNext;
          if (r_count == '0) begin
            r_result <= w_prodNext;
            r_zero   <= (w_prodNext == '0);
            r_ovf    <= 1'b0;
          end else begin
            r_count <= r_count - 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_exec.sv
// Randomised self-checking bench for alu_seq_exec against a funct-level reference model.
module tb_alu_seq_exec;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_alu_op = '0;
  logic [5:0]  in_funct = '0;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_result;
  logic        out_zero;
  logic        out_ovf;
  int          checks = 0;
  int          errors = 0;

  alu_seq_exec #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_alu_op(in_alu_op), .in_funct(in_funct), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_zero(out_zero), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  // Reference: the ALUop is folded into an effective funct, then evaluated with plain arithmetic.
  function automatic logic [31:0] modelResult(input logic [1:0] op, input logic [5:0] f,
                                              input logic [31:0] a, input logic [31:0] b,
                                              output logic ovf, output int lat);
    logic [5:0]  fe;
    longint      sa;
    longint      sb;
    longint      sfull;
    logic [63:0] prod;
    logic [31:0] r;
    int          k;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    k   = int'(b[4:0]);
    ovf = 1'b0;
    lat = 1;
    fe  = (op == 2'b10) ? f : ((op == 2'b01) ? 6'b100010 : 6'b100000);
    case (fe)
      6'b100010: begin r = a - b; sfull = sa - sb; ovf = (sfull != longint'($signed(r))); end
      6'b100100: r = a & b;
      6'b100101: r = a | b;
      6'b100110: r = a ^ b;
      6'b100111: r = ~(a | b);
      6'b101010: r = (sa < sb) ? 32'd1 : 32'd0;
      6'b101011: r = (a < b) ? 32'd1 : 32'd0;
      6'b000000: begin r = a << k; lat = (k == 0) ? 1 : k + 1; end
      6'b000010: begin r = a >> k; lat = (k == 0) ? 1 : k + 1; end
      6'b000011: begin r = $unsigned($signed(a) >>> k); lat = (k == 0) ? 1 : k + 1; end
`ifdef ALU_SEQ_MULT_EN
      6'b011001: begin prod = {32'd0, a} * {32'd0, b}; r = prod[31:0]; lat = 33; end
`endif
      default: begin r = a + b; sfull = sa + sb; ovf = (sfull != longint'($signed(r))); end
    endcase
    return r;
  endfunction

  task automatic sendOp(input logic [1:0] op, input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b, output int lat);
    int n = 0;
    while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
    in_valid = 1'b1; in_alu_op = op; in_funct = f; in_a = a; in_b = b;
    @(posedge clk); #1;
    in_valid = 1'b0; in_alu_op = 2'($urandom); in_funct = 6'($urandom);
    in_a = $urandom; in_b = $urandom;
    lat = 1;
    while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    if (!out_valid) lat = -1;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", out_valid); end
    checks++; if (out_result !== 32'd0) begin errors++; $display("FAIL rst_result got %h want 0", out_result); end
    checks++; if ({out_zero, out_ovf} !== 2'b00) begin errors++; $display("FAIL rst_flags got %b want 00", {out_zero, out_ovf}); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready_low got %b want 0", in_ready); end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready_high got %b want 1", in_ready); end
  endtask

  task automatic test_add_hold();
    int lat;
    sendOp(2'b00, 6'd0, 32'd5, 32'd7, lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL add_latency got %0d want 1", lat); end
    checks++; if (out_result !== 32'd12) begin errors++; $display("FAIL add_result got %h want 0000000c", out_result); end
    checks++; if ({out_zero, out_ovf} !== 2'b00) begin errors++; $display("FAIL add_flags got %b want 00", {out_zero, out_ovf}); end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++; if ({out_valid, in_ready, out_result} !== {1'b1, 1'b0, 32'd12})
        begin errors++; $display("FAIL hold_stable cycle %0d got v=%b r=%b res=%h want v=1 r=0 res=0000000c", i, out_valid, in_ready, out_result); end
    end
    consume();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL consume_valid got %b want 0", out_valid); end
  endtask

  task automatic test_sub_slt();
    int lat;
    sendOp(2'b10, 6'b100010, 32'h8000_0000, 32'd1, lat);
    checks++; if (out_result !== 32'h7FFF_FFFF) begin errors++; $display("FAIL sub_result got %h want 7fffffff", out_result); end
    checks++; if (out_ovf !== 1'b1) begin errors++; $display("FAIL sub_ovf got %b want 1", out_ovf); end
    consume();
    sendOp(2'b10, 6'b101010, 32'hFFFF_FFFF, 32'd0, lat);
    checks++; if (out_result !== 32'd1) begin errors++; $display("FAIL slt_result got %h want 00000001", out_result); end
    consume();
    sendOp(2'b10, 6'b101011, 32'hFFFF_FFFF, 32'd0, lat);
    checks++; if ({out_result, out_zero} !== {32'd0, 1'b1}) begin errors++; $display("FAIL sltu_result got %h z=%b want 00000000 z=1", out_result, out_zero); end
    consume();
  endtask

  task automatic test_shift();
    int lat;
    sendOp(2'b10, 6'b000011, 32'h8000_0000, 32'd4, lat);
    checks++; if (lat !== 5) begin errors++; $display("FAIL sra_latency got %0d want 5", lat); end
    checks++; if (out_result !== 32'hF800_0000) begin errors++; $display("FAIL sra_result got %h want f8000000", out_result); end
    consume();
    sendOp(2'b10, 6'b000000, 32'hDEAD_BEEF, 32'd0, lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL sll0_latency got %0d want 1", lat); end
    checks++; if (out_result !== 32'hDEAD_BEEF) begin errors++; $display("FAIL sll0_result got %h want deadbeef", out_result); end
    consume();
  endtask

  task automatic test_branch_default();
    int lat;
    sendOp(2'b01, 6'd0, 32'h1234, 32'h1234, lat);
    checks++; if ({out_result, out_zero} !== {32'd0, 1'b1}) begin errors++; $display("FAIL beq_result got %h z=%b want 0 z=1", out_result, out_zero); end
    consume();
    sendOp(2'b11, 6'b111111, 32'd3, 32'd4, lat);
    checks++; if (out_result !== 32'd7) begin errors++; $display("FAIL reserved_op got %h want 00000007", out_result); end
    consume();
    sendOp(2'b10, 6'b111111, 32'd3, 32'd4, lat);
    checks++; if (out_result !== 32'd7) begin errors++; $display("FAIL unknown_funct got %h want 00000007", out_result); end
    consume();
  endtask

  task automatic test_reset_mid_shift();
    int lat;
    in_valid = 1'b1; in_alu_op = 2'b10; in_funct = 6'b000000; in_a = 32'd1; in_b = 32'd20;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if ({out_valid, in_ready} !== 2'b00) begin errors++; $display("FAIL midrst_hs got v=%b r=%b want 00", out_valid, in_ready); end
    checks++; if (out_result !== 32'd0) begin errors++; $display("FAIL midrst_result got %h want 0", out_result); end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if ({in_ready, out_valid} !== 2'b10) begin errors++; $display("FAIL midrst_release got r=%b v=%b want r=1 v=0", in_ready, out_valid); end
    sendOp(2'b00, 6'd0, 32'd100, 32'd23, lat);
    checks++; if ({lat == 1, out_result} !== {1'b1, 32'd123}) begin errors++; $display("FAIL post_rst_add got lat=%0d res=%h want lat=1 res=0000007b", lat, out_result); end
    consume();
  endtask

  task automatic test_mult();
    int          lat;
    int          wantLat;
    logic        wantOvf;
    logic [31:0] want;
    want = modelResult(2'b10, 6'b011001, 32'h0001_0001, 32'h0001_0001, wantOvf, wantLat);
    sendOp(2'b10, 6'b011001, 32'h0001_0001, 32'h0001_0001, lat);
    checks++; if (lat !== wantLat) begin errors++; $display("FAIL multu_latency got %0d want %0d", lat, wantLat); end
    checks++; if (out_result !== want) begin errors++; $display("FAIL multu_result got %h want %h", out_result, want); end
    consume();
  endtask

  task automatic test_random();
    logic [5:0]  fl [13] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110, 6'b100111,
                             6'b101010, 6'b101011, 6'b000000, 6'b000010, 6'b000011, 6'b011001, 6'b010101};
    logic [1:0]  op;
    logic [5:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] want;
    logic        wantOvf;
    int          wantLat;
    int          lat;
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom);
      f  = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fl[$urandom_range(0, 12)];
      a  = $urandom;
      b  = ($urandom_range(0, 4) == 0) ? a : $urandom;
      if ($urandom_range(0, 3) == 0) a = {1'b0, 31'($urandom)} | 32'h4000_0000;
      want = modelResult(op, f, a, b, wantOvf, wantLat);
      sendOp(op, f, a, b, lat);
      checks++; if ({lat, out_result} !== {wantLat, want})
        begin errors++; $display("FAIL rand_result op=%b f=%b a=%h b=%h got lat=%0d res=%h want lat=%0d res=%h", op, f, a, b, lat, out_result, wantLat, want); end
      checks++; if ({out_zero, out_ovf} !== {want == 32'd0, wantOvf})
        begin errors++; $display("FAIL rand_flags op=%b f=%b got %b want %b", op, f, {out_zero, out_ovf}, {want == 32'd0, wantOvf}); end
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      checks++; if ({out_valid, out_result} !== {1'b1, want})
        begin errors++; $display("FAIL rand_hold got v=%b res=%h want v=1 res=%h", out_valid, out_result, want); end
      consume();
    end
  endtask

  task automatic test_back_to_back();
    in_valid = 1'b1; in_alu_op = 2'b00; in_a = 32'd1; in_b = 32'd2;
    @(posedge clk); #1;
    in_a = 32'd10; in_b = 32'd20;
    @(posedge clk); #1;
    checks++; if ({out_valid, in_ready, out_result} !== {1'b1, 1'b0, 32'd3})
      begin errors++; $display("FAIL b2b_first got v=%b r=%b res=%h want v=1 r=0 res=00000003", out_valid, in_ready, out_result); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++; if ({out_valid, in_ready} !== 2'b01) begin errors++; $display("FAIL b2b_gap got v=%b r=%b want v=0 r=1", out_valid, in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if ({out_valid, out_result} !== {1'b1, 32'd30})
      begin errors++; $display("FAIL b2b_second got v=%b res=%h want v=1 res=0000001e", out_valid, out_result); end
    consume();
  endtask

  initial begin
    test_reset();
    test_add_hold();
    test_sub_slt();
    test_shift();
    test_branch_default();
    test_reset_mid_shift();
    test_mult();
    test_random();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
